// File: rtl/fifo_reader.sv
// Read-side drain for a router input FIFO: issues credit-limited reads, captures the
// one-cycle-late read data into a small skid buffer and presents it as a valid/ready stream.
`timescale 1ns/1ps

module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 2,
   parameter int ID         = 0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]            fifo_data_i,
   output logic                             fifo_rd_en_o,
   output logic                             valid_o,
   output logic [DATA_WIDTH-1:0]            data_o,
   input  logic                             ready_i,
   output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy_o
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH+1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

   if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH-1)) != 0) begin : g_bad_depth
      $error("fifo_reader[%0d]: BUF_DEPTH must be a power of two >= 2", ID);
   end

   logic                  pend_q, pend_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic                  pop;
   logic [CW:0]           credit;

   assign valid_o     = (count_q != '0);
   assign data_o      = mem_q[rd_ptr_q];
   assign occupancy_o = count_q;

   always_comb begin
      pop    = valid_o && ready_i;
      // Occupancy one cycle from now, counting the read already in flight.
      credit = {1'b0, count_q} + (CW+1)'(pend_q) - (CW+1)'(pop);
      fifo_rd_en_o = rst_ni && !fifo_empty_i && (credit < DEPTH_C);

      pend_d   = fifo_rd_en_o;
      count_d  = credit[CW-1:0];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (pend_q) begin
         mem_d[wr_ptr_q] = fifo_data_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q   <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pend_q   <= pend_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

`ifndef SYNTHESIS
   a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CW'(BUF_DEPTH));
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pend_q && count_q == CW'(BUF_DEPTH) && !pop));
   a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_rd_en_o && fifo_empty_i));
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and randomized-ready bench for fifo_reader with a behavioral registered-read FIFO.
`timescale 1ns/1ps

module tb_fifo_reader;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_rd_en;
   logic       valid_o;
   logic [7:0] data_o;
   logic       ready_i = 1'b0;
   logic [1:0] occupancy_o;

   int         checks = 0;
   int         errors = 0;

   logic [7:0] fq[$];
   int         fcount = 0;
   int         underflow_cnt = 0;
   int         overflow_cnt = 0;
   int         push_cnt = 0;
   logic [7:0] push_vals [4];

   fifo_reader #(.DATA_WIDTH(8), .BUF_DEPTH(2), .ID(0)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .fifo_empty_i (fifo_empty),
      .fifo_data_i  (fifo_data),
      .fifo_rd_en_o (fifo_rd_en),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .ready_i      (ready_i),
      .occupancy_o  (occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   // Attached FIFO: registered read data, empty flag updates after the edge, depth 16.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fq.delete();
         fifo_data <= 8'h00;
         fcount    <= 0;
      end else begin
         if (fifo_rd_en) begin
            if (fq.size() == 0) underflow_cnt <= underflow_cnt + 1;
            else                fifo_data <= fq.pop_front();
         end
         for (int i = 0; i < push_cnt; i++) begin
            if (fq.size() >= 16) overflow_cnt <= overflow_cnt + 1;
            else                 fq.push_back(push_vals[i]);
         end
         fcount <= fq.size();
      end
   end

   assign fifo_empty = (fcount == 0);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load(input int n, input logic [7:0] v0, input logic [7:0] v1,
                       input logic [7:0] v2, input logic [7:0] v3);
      push_vals[0] = v0; push_vals[1] = v1; push_vals[2] = v2; push_vals[3] = v3;
      push_cnt = n;
      step();
      push_cnt = 0;
   endtask

   logic [7:0] exp_q[$];
   int         rd_cnt;
   int         tx, rx, max_occ;
   bit         got;
   bit         exp_rd [8];
   bit         exp_vld [8];

   initial begin
      // Reset
      repeat (3) step();
      check_eq("rst_valid", valid_o, 0);
      check_eq("rst_data", data_o, 8'h00);
      check_eq("rst_occ", occupancy_o, 0);
      check_eq("rst_rden", fifo_rd_en, 0);
      rst_ni = 1'b1;
      repeat (3) step();
      check_eq("idle_valid", valid_o, 0);
      check_eq("idle_rden", fifo_rd_en, 0);
      check_eq("idle_occ", occupancy_o, 0);

      // Single flit
      ready_i = 1'b1;
      load(1, 8'hA5, 8'h00, 8'h00, 8'h00);
      check_eq("single_rd_t", fifo_rd_en, 1);
      check_eq("single_vld_t", valid_o, 0);
      step();
      check_eq("single_rd_t1", fifo_rd_en, 0);
      check_eq("single_vld_t1", valid_o, 0);
      step();
      check_eq("single_vld_t2", valid_o, 1);
      check_eq("single_data_t2", data_o, 8'hA5);
      step();
      check_eq("single_vld_t3", valid_o, 0);
      check_eq("single_rd_t3", fifo_rd_en, 0);

      // Streaming at full throughput
      exp_rd  = '{1, 1, 1, 1, 0, 0, 0, 0};
      exp_vld = '{0, 0, 1, 1, 1, 1, 0, 0};
      load(4, 8'h01, 8'h02, 8'h03, 8'h04);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("stream_rd%0d", i), fifo_rd_en, exp_rd[i]);
         check_eq($sformatf("stream_vld%0d", i), valid_o, exp_vld[i]);
         if (exp_vld[i]) check_eq($sformatf("stream_data%0d", i), data_o, i - 1);
         step();
      end

      // Backpressure then resume
      ready_i = 1'b0;
      load(4, 8'h01, 8'h02, 8'h03, 8'h04);
      rd_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (fifo_rd_en) rd_cnt++;
         step();
      end
      check_eq("bp_reads", rd_cnt, 2);
      check_eq("bp_occ", occupancy_o, 2);
      check_eq("bp_valid", valid_o, 1);
      check_eq("bp_data", data_o, 8'h01);
      check_eq("bp_fifo_left", fcount, 2);
      check_eq("bp_rden", fifo_rd_en, 0);
      ready_i = 1'b1;
      #1;
      check_eq("resume_rd_same_cycle", fifo_rd_en, 1);
      exp_vld = '{1, 1, 1, 1, 0, 0, 0, 0};
      exp_rd  = '{1, 1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("resume_vld%0d", i), valid_o, exp_vld[i]);
         check_eq($sformatf("resume_rd%0d", i), fifo_rd_en, exp_rd[i]);
         if (exp_vld[i]) check_eq($sformatf("resume_data%0d", i), data_o, i + 1);
         step();
      end

      // Random ready and random FIFO writes
      tx = 0; rx = 0; max_occ = 0;
      for (int cyc = 0; cyc < 5000 && rx < 200; cyc++) begin
         ready_i = 1'($urandom_range(0, 1));
         if (tx < 200 && fcount < 12 && $urandom_range(0, 1) == 1) begin
            push_vals[0] = 8'(tx * 7 + 3);
            push_cnt = 1;
            exp_q.push_back(8'(tx * 7 + 3));
            tx++;
         end else begin
            push_cnt = 0;
         end
         if (int'(occupancy_o) > max_occ) max_occ = int'(occupancy_o);
         #1;
         if (valid_o && ready_i) begin
            check_eq($sformatf("rand_data%0d", rx), data_o, exp_q.pop_front());
            rx++;
         end
         step();
      end
      push_cnt = 0;
      ready_i  = 1'b0;
      check_eq("rand_delivered", rx, 200);
      check_eq("rand_max_occ_ok", (max_occ <= 2), 1);
      check_eq("underflow", underflow_cnt, 0);
      check_eq("overflow", overflow_cnt, 0);

      // Reset mid-stream
      load(4, 8'h10, 8'h11, 8'h12, 8'h13);
      repeat (3) step();
      check_eq("mid_occ_before", occupancy_o, 2);
      rst_ni = 1'b0;
      #1;
      check_eq("mid_rst_valid", valid_o, 0);
      check_eq("mid_rst_occ", occupancy_o, 0);
      check_eq("mid_rst_data", data_o, 8'h00);
      check_eq("mid_rst_rden", fifo_rd_en, 0);
      repeat (2) step();
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      load(1, 8'h5A, 8'h00, 8'h00, 8'h00);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (valid_o) got = 1'b1;
         else         step();
      end
      check_eq("post_rst_got", got, 1);
      check_eq("post_rst_data", data_o, 8'h5A);
      step();
      check_eq("post_rst_empty", valid_o, 0);
      check_eq("final_underflow", underflow_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
